// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and helpers for the PDM CIC decimator.
//   CIC_ORDER  - number of integrator/comb stages per channel
//   DC_SHIFT   - pole position of the optional DC-removal high-pass
//   calc_acc_w - integrator/comb width for a given log2 decimation ratio
//   sat_trunc  - arithmetic right shift followed by clamp to a signed width
package pdm_pkg;

    localparam int CIC_ORDER = 3;
    localparam int DC_SHIFT  = 10;

    // Bit growth of an order-N CIC with decimation 2^log2_decim is
    // N*log2_decim bits; two extra bits cover the +/-1 input and the sign.
    function automatic int calc_acc_w(input int log2_decim);
        return 2 + CIC_ORDER * log2_decim;
    endfunction

    // Result is returned sign-extended to 32 bits; callers keep the low
    // out_w bits, which are guaranteed to represent the clamped value.
    function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] x,
                                                     input int shift,
                                                     input int out_w);
        logic signed [31:0] s;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        s     = x >>> shift;
        max_v = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (out_w - 1));
        if (s > max_v) begin
            return max_v;
        end else if (s < min_v) begin
            return min_v;
        end
        return s;
    endfunction

endpackage

// File: rtl/pdm_cic_decimator_cic3_channel.sv
// cic3_channel: one channel of the 3rd-order CIC decimator.
// Optional build macro: PDM_DC_BLOCK_EN adds a DC-removal high-pass after
// saturation (one extra clk of latency).
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   clr           - synchronous clear of filter state (pcm holds)
//   sample_en     - this channel's PDM sample cycle
//   sample_bit    - synchronised PDM bit (1 -> +1, 0 -> -1)
//   snap_en       - decimation event; snapshot the last integrator
//   comb_en       - evaluate the comb chain on the snapshot
//   load_en       - update the output (or start the high-pass stage)
//   pcm           - signed output sample
module cic3_channel
    import pdm_pkg::*;
#(
    parameter int LOG2_DECIM = 6,
    parameter int OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    sample_en,
    input  logic                    sample_bit,
    input  logic                    snap_en,
    input  logic                    comb_en,
    input  logic                    load_en,
    output logic signed [OUT_W-1:0] pcm
);

    localparam int ACC_W = calc_acc_w(LOG2_DECIM);
    localparam int SHIFT = CIC_ORDER * LOG2_DECIM + 1 - OUT_W;

    if (SHIFT < 0) begin : g_shift_check
        $error("cic3_channel: OUT_W too wide for LOG2_DECIM (negative output shift)");
    end

    logic signed [ACC_W-1:0] x_in;
    logic signed [ACC_W-1:0] i1, i2, i3;
    logic signed [ACC_W-1:0] i1_nxt, i2_nxt, i3_nxt;
    logic signed [ACC_W-1:0] i3_now;
    logic signed [ACC_W-1:0] snap;
    logic signed [ACC_W-1:0] d1, d2, d3;
    logic signed [ACC_W-1:0] c1, c2, c3;
    logic signed [31:0]      sat32;
    logic signed [OUT_W-1:0] sat_val;

    always_comb begin
        x_in   = sample_bit ? ACC_W'(1) : '1;
        // Integrators chain combinationally so every stage sees this
        // cycle's sample; wrap-around is intentional and cancels in the combs.
        i1_nxt = i1 + x_in;
        i2_nxt = i2 + i1_nxt;
        i3_nxt = i3 + i2_nxt;
        // A sample arriving in the decimation cycle belongs to this frame.
        i3_now = sample_en ? i3_nxt : i3;
        c1     = snap - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
        sat32  = sat_trunc(32'(c3), SHIFT, OUT_W);
        sat_val = sat32[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i1 <= '0; i2 <= '0; i3 <= '0;
            snap <= '0;
            d1 <= '0; d2 <= '0; d3 <= '0;
        end else if (clr) begin
            i1 <= '0; i2 <= '0; i3 <= '0;
            snap <= '0;
            d1 <= '0; d2 <= '0; d3 <= '0;
        end else begin
            if (sample_en) begin
                i1 <= i1_nxt;
                i2 <= i2_nxt;
                i3 <= i3_nxt;
            end
            if (snap_en) begin
                snap <= i3_now;
            end
            if (comb_en) begin
                d1 <= snap;
                d2 <= c1;
                d3 <= c2;
            end
        end
    end

`ifdef PDM_DC_BLOCK_EN
    localparam int HP_W = OUT_W + 4;

    logic signed [OUT_W-1:0] x_hold, x_prev, y_prev;
    logic                    hp_pend;
    logic signed [HP_W-1:0]  hp_sum;
    logic signed [31:0]      hp_sat32;
    logic signed [OUT_W-1:0] hp_val;

    // y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), computed wide.
    always_comb begin
        hp_sum   = HP_W'(x_hold) - HP_W'(x_prev) + HP_W'(y_prev)
                   - HP_W'(y_prev >>> DC_SHIFT);
        hp_sat32 = sat_trunc(32'(hp_sum), 0, OUT_W);
        hp_val   = hp_sat32[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_hold <= '0; x_prev <= '0; y_prev <= '0;
            hp_pend <= 1'b0;
            pcm <= '0;
        end else if (clr) begin
            x_hold <= '0; x_prev <= '0; y_prev <= '0;
            hp_pend <= 1'b0;
        end else begin
            hp_pend <= load_en;
            if (load_en) begin
                x_hold <= sat_val;
            end
            if (hp_pend) begin
                x_prev <= x_hold;
                y_prev <= hp_val;
                pcm    <= hp_val;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcm <= '0;
        end else if (!clr && load_en) begin
            pcm <= sat_val;
        end
    end
`endif

endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: stereo PDM capture and 3rd-order CIC decimation.
// Left mic sampled on pdm_clk falling edges, right mic on rising edges.
// Optional build macro: PDM_DC_BLOCK_EN (DC-removal high-pass, +1 clk latency).
// Ports:
//   clk, reset_n         - system clock, asynchronous active-low reset
//   pdm_clk              - divided mic clock (from a clk-domain flop)
//   pdm_data             - PDM pad data, asynchronous to clk
//   enable               - run/stop; low clears filter state, pcm holds
//   pcm_left, pcm_right  - signed PCM samples
//   pcm_valid            - one-clk strobe when both pcm outputs update
// Handshake: pcm_valid is a push-only strobe with no ready; the consumer
// must capture pcm_left/pcm_right in the cycle pcm_valid is high.
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int LOG2_DECIM = 6,
    parameter int OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pdm_clk,
    input  logic                    pdm_data,
    input  logic                    enable,
    output logic signed [OUT_W-1:0] pcm_left,
    output logic signed [OUT_W-1:0] pcm_right,
    output logic                    pcm_valid
);

    logic                  data_s1, data_s2;
    logic                  pdm_clk_d1;
    logic                  rise, fall;
    logic                  dec_evt;
    logic                  startup_done;
    logic [LOG2_DECIM-1:0] dec_cnt;
    logic [1:0]            startup_cnt;
    logic                  comb_pend;
    logic                  emit_d1;
`ifdef PDM_DC_BLOCK_EN
    logic                  emit_d2;
`endif

    // Synchronisers and edge history run regardless of enable so that the
    // first edge after re-enable is seen correctly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_s1    <= 1'b0;
            data_s2    <= 1'b0;
            pdm_clk_d1 <= 1'b0;
        end else begin
            data_s1    <= pdm_data;
            data_s2    <= data_s1;
            pdm_clk_d1 <= pdm_clk;
        end
    end

    always_comb begin
        fall         = pdm_clk_d1 & ~pdm_clk;
        rise         = ~pdm_clk_d1 & pdm_clk;
        dec_evt      = rise && (dec_cnt == {LOG2_DECIM{1'b1}});
        // The first three events only prime the comb delays.
        startup_done = (startup_cnt == 2'd3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_cnt     <= '0;
            startup_cnt <= '0;
            comb_pend   <= 1'b0;
            emit_d1     <= 1'b0;
`ifdef PDM_DC_BLOCK_EN
            emit_d2     <= 1'b0;
`endif
            pcm_valid   <= 1'b0;
        end else if (!enable) begin
            dec_cnt     <= '0;
            startup_cnt <= '0;
            comb_pend   <= 1'b0;
            emit_d1     <= 1'b0;
`ifdef PDM_DC_BLOCK_EN
            emit_d2     <= 1'b0;
`endif
            pcm_valid   <= 1'b0;
        end else begin
            if (rise) begin
                dec_cnt <= dec_cnt + 1'b1;
            end
            if (dec_evt && !startup_done) begin
                startup_cnt <= startup_cnt + 2'd1;
            end
            comb_pend <= dec_evt;
            emit_d1   <= dec_evt && startup_done;
`ifdef PDM_DC_BLOCK_EN
            emit_d2   <= emit_d1;
            pcm_valid <= emit_d2;
`else
            pcm_valid <= emit_d1;
`endif
        end
    end

    cic3_channel #(.LOG2_DECIM(LOG2_DECIM), .OUT_W(OUT_W)) u_left (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (~enable),
        .sample_en  (fall),
        .sample_bit (data_s2),
        .snap_en    (dec_evt),
        .comb_en    (comb_pend),
        .load_en    (emit_d1),
        .pcm        (pcm_left)
    );

    cic3_channel #(.LOG2_DECIM(LOG2_DECIM), .OUT_W(OUT_W)) u_right (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (~enable),
        .sample_en  (rise),
        .sample_bit (data_s2),
        .snap_en    (dec_evt),
        .comb_en    (comb_pend),
        .load_en    (emit_d1),
        .pcm        (pcm_right)
    );

endmodule
